multi_edge_detector: RTL and testbench

Parametrised multi-channel edge detector and successor to the single-bit XOR edge detector. Each channel synchronises an asynchronous input, detects rise, fall or both edges according to a runtime mode, and emits a one-cycle pulse. Detected events also set a sticky flag and increment a saturating event counter. Sits between raw GPIO/status lines and the interrupt/status register block.

---
 rtl/edge_det_pkg.sv | 22 ++
 rtl/edge_det_chan.sv | 107 ++++++++++
 rtl/multi_edge_detector.sv | 81 ++++++++
 tb/tb_multi_edge_detector.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_det_pkg.sv
// Shared mode encodings and the saturating-increment helper for the
// multi-channel edge detector.
package edge_det_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_OFF  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_RISE = 2'b01;
  localparam logic [MODE_W-1:0] MODE_FALL = 2'b10;
  localparam logic [MODE_W-1:0] MODE_BOTH = 2'b11;

  // Widest supported event counter; narrower counters are cast in and out.
  localparam int CNT_MAX_W = 16;

  function automatic logic [CNT_MAX_W-1:0] sat_inc(
    input logic [CNT_MAX_W-1:0] value,
    input logic [CNT_MAX_W-1:0] max_value
  );
    return (value >= max_value) ? value : value + CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One detector channel: synchroniser, optional deglitch filter (DEGLITCH_EN),
// edge detect, sticky flag and saturating event counter.
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
`ifdef DEGLITCH_EN
  , parameter int FILT_LEN  = 4
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  input  logic              clr,
  input  logic              det_en,
  input  logic [MODE_W-1:0] mode,
  output logic              pulse,
  output logic              sticky,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_det;
  logic                   prev_q;
  logic                   rise;
  logic                   fall;
  logic                   event_hit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

`ifdef DEGLITCH_EN
  localparam int FILT_W = $clog2(FILT_LEN + 1);

  logic              filt_q;
  logic [FILT_W-1:0] run_q;

  // The filtered level follows s only after FILT_LEN consecutive disagreeing
  // samples; any agreeing sample restarts the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
      run_q <= '0;
    end else if (run_q == FILT_W'(FILT_LEN - 1)) begin
      filt_q <= sync_q[SYNC_STAGES-1];
      run_q  <= '0;
    end else begin
      run_q <= run_q + FILT_W'(1);
    end
  end

  assign s_det = filt_q;
`else
  assign s_det = sync_q[SYNC_STAGES-1];
`endif

  assign rise = s_det & ~prev_q;
  assign fall = ~s_det & prev_q;

  always_comb begin
    // NOTE: default first so no path leaves event_hit unassigned (no latch).
    event_hit = 1'b0;
    case (mode)
      MODE_RISE: event_hit = rise;
      MODE_FALL: event_hit = fall;
      MODE_BOTH: event_hit = rise | fall;
      default:   event_hit = 1'b0;
    endcase
    event_hit = event_hit & det_en;
  end

  // A clear in the same cycle as an event keeps the event: sticky stays set
  // and the counter restarts at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
      pulse  <= 1'b0;
      sticky <= 1'b0;
      count  <= '0;
    end else begin
      prev_q <= s_det;
      pulse  <= event_hit;
      sticky <= event_hit | (sticky & ~clr);
      if (clr) begin
        count <= event_hit ? CNT_W'(1) : '0;
      end else if (event_hit) begin
        count <= CNT_W'(sat_inc(CNT_MAX_W'(count), CNT_MAX_W'(CNT_MAX)));
      end
    end
  end

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector top: warm-up masking, per-channel detectors,
// registered irq reduction and counter readout. Optional filter: DEGLITCH_EN.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int FILT_LEN    = 4,
  localparam int SEL_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  din,
  input  logic [WIDTH-1:0]  clr,
  input  logic [WIDTH-1:0]  irq_mask,
  input  logic [SEL_W-1:0]  cnt_sel,
  output logic [WIDTH-1:0]  pulse,
  output logic [WIDTH-1:0]  sticky,
  output logic              irq,
  output logic [CNT_W-1:0]  cnt_rd
);

`ifdef DEGLITCH_EN
  localparam int FILT_ACTIVE = 1;
`else
  localparam int FILT_ACTIVE = 0;
`endif

  // Long enough for reset-time zeros to flush out of the sync/filter/prev
  // pipeline, so a line already high at reset never looks like a rise.
  localparam int WARM_INIT = SYNC_STAGES + FILT_ACTIVE * FILT_LEN + 1;
  localparam int WARM_W    = $clog2(WARM_INIT + 1);

  logic [WARM_W-1:0] warm_q;
  logic              det_en;
  logic [CNT_W-1:0]  count [WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      warm_q <= WARM_W'(WARM_INIT);
    end else if (warm_q != '0) begin
      warm_q <= warm_q - WARM_W'(1);
    end
  end

  assign det_en = en & (warm_q == '0);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
`ifdef DEGLITCH_EN
      , .FILT_LEN  (FILT_LEN)
`endif
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .din    (din[i]),
      .clr    (clr[i]),
      .det_en (det_en),
      .mode   (mode),
      .pulse  (pulse[i]),
      .sticky (sticky[i]),
      .count  (count[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq    <= 1'b0;
      cnt_rd <= '0;
    end else begin
      irq    <= |(sticky & irq_mask);
      cnt_rd <= (32'(cnt_sel) < WIDTH) ? count[cnt_sel] : '0;
    end
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: a sample-history reference
// model plus scenario tasks with directed expectations.
module tb_multi_edge_detector;

  localparam int WIDTH    = 8;
  localparam int SS       = 2;
  localparam int CNT_W    = 8;
  localparam int FILT_LEN = 4;
  localparam int SEL_W    = 3;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef DEGLITCH_EN
  localparam int FL_ACT   = FILT_LEN;
`else
  localparam int FL_ACT   = 0;
`endif
  localparam int WARM     = SS + FL_ACT + 1;
  localparam int OBS_W    = 2 * WIDTH + 1 + CNT_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irq_mask;
  logic [SEL_W-1:0] cnt_sel;
  logic [WIDTH-1:0] pulse;
  logic [WIDTH-1:0] sticky;
  logic             irq;
  logic [CNT_W-1:0] cnt_rd;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multi_edge_detector #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SS),
    .CNT_W       (CNT_W),
    .FILT_LEN    (FILT_LEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .din      (din),
    .clr      (clr),
    .irq_mask (irq_mask),
    .cnt_sel  (cnt_sel),
    .pulse    (pulse),
    .sticky   (sticky),
    .irq      (irq),
    .cnt_rd   (cnt_rd)
  );

  // Reference model: hist[j] holds din as sampled j+1 edges ago, so the
  // synchronised level is hist[SS-1] and the previous level is hist[SS].
  logic [WIDTH-1:0] hist [SS+1];
  logic [WIDTH-1:0] m_pulse;
  logic [WIDTH-1:0] m_sticky;
  logic             m_irq;
  logic [CNT_W-1:0] m_cnt_rd;
  int               m_cnt [WIDTH];
  int               since_rst;
`ifdef DEGLITCH_EN
  logic [WIDTH-1:0] m_filt;
  logic [WIDTH-1:0] m_fprev;
  logic [WIDTH-1:0] s_hist [FILT_LEN];
`endif

  always @(posedge clk) begin : ref_model
    logic [WIDTH-1:0] s_now, cur, prv, ev, rises, falls;
    if (reset) begin
      for (int j = 0; j <= SS; j++) hist[j] = '0;
      for (int c = 0; c < WIDTH; c++) m_cnt[c] = 0;
      m_pulse   = '0;
      m_sticky  = '0;
      m_irq     = 1'b0;
      m_cnt_rd  = '0;
      since_rst = 0;
`ifdef DEGLITCH_EN
      m_filt  = '0;
      m_fprev = '0;
      for (int j = 0; j < FILT_LEN; j++) s_hist[j] = '0;
`endif
    end else begin
      s_now = hist[SS-1];
`ifdef DEGLITCH_EN
      cur     = m_filt;
      prv     = m_fprev;
      m_fprev = m_filt;
      for (int j = FILT_LEN - 1; j > 0; j--) s_hist[j] = s_hist[j-1];
      s_hist[0] = s_now;
      for (int c = 0; c < WIDTH; c++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int j = 0; j < FILT_LEN; j++) if (s_hist[j][c] == m_filt[c]) all_diff = 1'b0;
        if (all_diff) m_filt[c] = s_now[c];
      end
`else
      cur = s_now;
      prv = hist[SS];
`endif
      rises = cur & ~prv;
      falls = ~cur & prv;
      case (mode)
        2'd1:    ev = rises;
        2'd2:    ev = falls;
        2'd3:    ev = rises | falls;
        default: ev = '0;
      endcase
      if (!en || since_rst < WARM) ev = '0;
      m_irq    = |(m_sticky & irq_mask);
      m_cnt_rd = (cnt_sel < WIDTH) ? CNT_W'(m_cnt[cnt_sel]) : '0;
      m_pulse  = ev;
      m_sticky = ev | (m_sticky & ~clr);
      for (int c = 0; c < WIDTH; c++) begin
        if (clr[c]) m_cnt[c] = ev[c] ? 1 : 0;
        else if (ev[c] && m_cnt[c] < CNT_MAX) m_cnt[c] = m_cnt[c] + 1;
      end
      for (int j = SS; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = din;
      if (since_rst < 1000000) since_rst = since_rst + 1;
    end
  end

  logic [OBS_W-1:0] obs_w;
  logic [OBS_W-1:0] exp_w;
  assign obs_w = {pulse, sticky, irq, cnt_rd};
  assign exp_w = {m_pulse, m_sticky, m_irq, m_cnt_rd};

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; din = '1; mode = 2'b11; en = 1'b1;
    irq_mask = '1; clr = '0; cnt_sel = '0;
    repeat (3) cycle();
    vectors++;
    if (obs_w !== '0) begin
      miscompares++;
      $display("FAIL reset_state got %h want 0", obs_w);
    end
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      vectors++;
      if (obs_w !== exp_w) begin
        miscompares++;
        $display("FAIL reset_model k=%0d got %h want %h", k, obs_w, exp_w);
      end
      vectors++;
      if (pulse !== '0 || sticky !== '0) begin
        miscompares++;
        $display("FAIL reset_no_spurious k=%0d pulse=%h sticky=%h want 0", k, pulse, sticky);
      end
    end
    for (int c = 0; c < WIDTH; c++) begin
      cnt_sel = SEL_W'(c);
      cycle();
      vectors++;
      if (cnt_rd !== '0) begin
        miscompares++;
        $display("FAIL reset_counter ch=%0d got %0d want 0", c, cnt_rd);
      end
    end
  endtask

  task automatic test_rise();
    mode = 2'b01; din = '0; cnt_sel = '0;
    repeat (6) cycle();
    din[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      vectors++;
      if (obs_w !== exp_w) begin
        miscompares++;
        $display("FAIL rise_model k=%0d got %h want %h", k, obs_w, exp_w);
      end
      vectors++;
      if (pulse[0] !== (k == SS + FL_ACT)) begin
        miscompares++;
        $display("FAIL rise_timing k=%0d got %b want %b", k, pulse[0], (k == SS + FL_ACT));
      end
    end
    din[0] = 1'b0;
    for (int k = 0; k < 6 + FL_ACT; k++) begin
      cycle();
      vectors++;
      if (pulse[0] !== 1'b0 || obs_w !== exp_w) begin
        miscompares++;
        $display("FAIL fall_ignored k=%0d got %h want %h", k, obs_w, exp_w);
      end
    end
    vectors++;
    if (cnt_rd !== CNT_W'(1)) begin
      miscompares++;
      $display("FAIL rise_count got %0d want 1", cnt_rd);
    end
  endtask

  task automatic test_clr_collision();
    irq_mask = 8'b0000_0100; clr = 8'b0000_0100; cnt_sel = 3'd2;
    cycle();
    clr = '0;
    repeat (2) cycle();
    din[2] = 1'b1;
    repeat (SS + FL_ACT) cycle();
    clr[2] = 1'b1;
    cycle();
    clr = '0;
    vectors++;
    if (sticky[2] !== 1'b1 || pulse[2] !== 1'b1 || irq !== 1'b0 || obs_w !== exp_w) begin
      miscompares++;
      $display("FAIL clr_collision sticky=%b pulse=%b irq=%b want 1 1 0 (all %h vs %h)",
               sticky[2], pulse[2], irq, obs_w, exp_w);
    end
    cycle();
    vectors++;
    if (irq !== 1'b1 || cnt_rd !== CNT_W'(1) || obs_w !== exp_w) begin
      miscompares++;
      $display("FAIL clr_irq irq=%b cnt=%0d want 1 1 (all %h vs %h)", irq, cnt_rd, obs_w, exp_w);
    end
  endtask

  task automatic test_en_gate();
    mode = 2'b11; clr[5] = 1'b1; cnt_sel = 3'd5;
    cycle();
    clr = '0; en = 1'b0;
    cycle();
    for (int t = 0; t < 3; t++) begin
      din[5] = ~din[5];
      repeat (2) cycle();
    end
    repeat (6 + FL_ACT) cycle();
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      vectors++;
      if (pulse[5] !== 1'b0 || sticky[5] !== 1'b0 || cnt_rd !== '0 || obs_w !== exp_w) begin
        miscompares++;
        $display("FAIL en_gate k=%0d pulse=%b sticky=%b cnt=%0d want 0 0 0 (all %h vs %h)",
                 k, pulse[5], sticky[5], cnt_rd, obs_w, exp_w);
      end
    end
  endtask

  task automatic test_back_to_back();
    mode = 2'b11; en = 1'b1; cnt_sel = 3'd3;
    for (int k = 0; k < 300; k++) begin
      din[3] = ~din[3];
      cycle();
      vectors++;
      if (obs_w !== exp_w) begin
        miscompares++;
        $display("FAIL b2b_model k=%0d got %h want %h", k, obs_w, exp_w);
      end
`ifndef DEGLITCH_EN
      if (k >= SS) begin
        vectors++;
        if (pulse[3] !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_pulse k=%0d got %b want 1", k, pulse[3]);
        end
      end
`endif
    end
    repeat (4) cycle();
`ifndef DEGLITCH_EN
    vectors++;
    if (cnt_rd !== CNT_W'(CNT_MAX)) begin
      miscompares++;
      $display("FAIL b2b_saturate got %0d want %0d", cnt_rd, CNT_MAX);
    end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      reset    = ($urandom_range(0, 199) == 0);
      din      = din ^ WIDTH'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      en       = ($urandom_range(0, 9) != 0);
      clr      = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : '0;
      if ($urandom_range(0, 31) == 0) irq_mask = WIDTH'($urandom);
      cnt_sel  = SEL_W'($urandom);
      cycle();
      vectors++;
      if (obs_w !== exp_w) begin
        miscompares++;
        $display("FAIL random k=%0d got %h want %h", k, obs_w, exp_w);
      end
    end
    reset = 1'b0; clr = '0; en = 1'b1;
  endtask

`ifdef DEGLITCH_EN
  task automatic test_deglitch();
    int hits;
    int hit_k;
    mode = 2'b01; din = '0; clr = '0;
    repeat (12) cycle();
    din[1] = 1'b1;
    repeat (3) cycle();
    din[1] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cycle();
      vectors++;
      if (pulse[1] !== 1'b0 || obs_w !== exp_w) begin
        miscompares++;
        $display("FAIL glitch_reject k=%0d got %h want %h", k, obs_w, exp_w);
      end
    end
    hits = 0; hit_k = -1;
    din[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (k == 4) din[1] = 1'b0;
      if (pulse[1] === 1'b1) begin
        hits++;
        if (hit_k < 0) hit_k = k;
      end
    end
    vectors++;
    if (hits !== 1 || hit_k !== SS + FILT_LEN) begin
      miscompares++;
      $display("FAIL deglitch_pulse hits=%0d at=%0d want 1 at %0d", hits, hit_k, SS + FILT_LEN);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; en = 1'b1; mode = '0; din = '0;
    clr = '0; irq_mask = '0; cnt_sel = '0;
    test_reset();
    test_rise();
    test_clr_collision();
    test_en_gate();
    test_back_to_back();
    test_random();
`ifdef DEGLITCH_EN
    test_deglitch();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
